// File: rtl/ms_wb_uart_master.sv
// Wishbone classic initiator fed by UART bytes: 'W' A3..A0 D3..D0 writes, 'R' A3..A0 reads.
// Optional bus watchdog enabled by defining WB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module ms_wb_uart_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;
  localparam logic [7:0] RSP_T = 8'h54;

  state_t      state_r, state_s;
  logic [1:0]  cnt_r, cnt_s;
  logic [31:0] rd_r, rd_s;
  logic        cyc_s, stb_s, we_s, txv_s;
  logic [3:0]  sel_s;
  logic [31:0] adr_s, dat_s;
  logic [7:0]  txd_s;
  logic        tmo_hit_s;

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_r;

  // Watchdog: zero outside BUS, so it restarts every time stb_o rises
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_r <= 16'd0;
    end else if (state_r != ST_BUS) begin
      tmo_r <= 16'd0;
    end else begin
      tmo_r <= tmo_r + 16'd1;
    end
  end

  assign tmo_hit_s = (state_r == ST_BUS) && (tmo_r == TMO_LAST);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and next-output logic; cnt_r counts bytes in ADDR/DATA and bytes left to send in RESP
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rd_s    = rd_r;
    cyc_s   = cyc_o;
    stb_s   = stb_o;
    we_s    = we_o;
    sel_s   = sel_o;
    adr_s   = adr_o;
    dat_s   = dat_o;
    txd_s   = tx_data;
    txv_s   = tx_valid;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid) begin
          cnt_s = 2'd0;
          if ((rx_data == CMD_W) || (rx_data == CMD_R)) begin
            state_s = ST_ADDR;
            we_s    = (rx_data == CMD_W);
          end else begin
            state_s = ST_RESP;
            txd_s   = RSP_E;
            txv_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          adr_s = {adr_o[23:0], rx_data};
          cnt_s = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            if (we_o) begin
              state_s = ST_DATA;
              cnt_s   = 2'd0;
            end else begin
              state_s = ST_BUS;
              cyc_s   = 1'b1;
              stb_s   = 1'b1;
              sel_s   = 4'hF;
            end
          end else begin
            state_s = ST_ADDR;
          end
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          dat_s = {dat_o[23:0], rx_data};
          cnt_s = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            state_s = ST_BUS;
            cyc_s   = 1'b1;
            stb_s   = 1'b1;
            sel_s   = 4'hF;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_BUS: begin
        // an ack in the expiry cycle takes priority over the watchdog
        if (ack_i) begin
          state_s = ST_RESP;
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          sel_s   = 4'h0;
          txv_s   = 1'b1;
          if (we_o) begin
            txd_s = RSP_K;
            cnt_s = 2'd0;
          end else begin
            txd_s = dat_i[31:24];
            rd_s  = {dat_i[23:0], 8'h00};
            cnt_s = 2'd3;
          end
        end else if (tmo_hit_s) begin
          state_s = ST_RESP;
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          sel_s   = 4'h0;
          txv_s   = 1'b1;
          txd_s   = RSP_T;
          cnt_s   = 2'd0;
        end else begin
          state_s = ST_BUS;
        end
      end
      ST_RESP: begin
        if (tx_ready) begin
          if (cnt_r != 2'd0) begin
            txd_s = rd_r[31:24];
            rd_s  = {rd_r[23:0], 8'h00};
            cnt_s = cnt_r - 2'd1;
          end else begin
            txv_s   = 1'b0;
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cyc_s   = 1'b0;
        stb_s   = 1'b0;
        sel_s   = 4'h0;
        txv_s   = 1'b0;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 2'd0;
      rd_r     <= 32'h0000_0000;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      we_o     <= 1'b0;
      sel_o    <= 4'h0;
      adr_o    <= 32'h0000_0000;
      dat_o    <= 32'h0000_0000;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rd_r     <= rd_s;
      cyc_o    <= cyc_s;
      stb_o    <= stb_s;
      we_o     <= we_s;
      sel_o    <= sel_s;
      adr_o    <= adr_s;
      dat_o    <= dat_s;
      tx_data  <= txd_s;
      tx_valid <= txv_s;
      busy_o   <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ms_wb_uart_master.sv
// Self-checking bench for ms_wb_uart_master: vector table, corner sequences, random frames vs. a frame-level model.
// Inputs change and outputs are sampled on the falling edge.
module tb_ms_wb_uart_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        cyc_o, stb_o, we_o, busy_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  ms_wb_uart_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .busy_o(busy_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          stable;
    bit          acked;
    int          cycles;
  } acc_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    int          dly;
    bit          e_acc;
    int          e_n;
    logic [31:0] e_rep;
  } vec_t;

  int          n_checks = 0;
  int          n_pass = 0;
  int          hold_err = 0;
  int          stall_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          no_ack = 1'b0;
  int          ack_dly = 0;
  logic [31:0] rdata = 32'h0;
  logic [7:0]  reply_q[$];
  acc_t        acc_q[$];
  acc_t        cur;
  bit          in_acc = 1'b0;
  bit          acked = 1'b0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Slave: acks in stb cycle ack_dly+1 and logs one record per stb pulse
  initial begin
    forever begin
      @(negedge clk_i);
      if (acked || (in_acc && !(cyc_o && stb_o))) begin
        acc_q.push_back(cur);
        in_acc = 1'b0;
        acked  = 1'b0;
      end
      ack_i = 1'b0;
      dat_i = $urandom;
      if (cyc_o && stb_o) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          cur.we = we_o; cur.adr = adr_o; cur.dat = dat_o; cur.sel = sel_o;
          cur.stable = 1'b1; cur.acked = 1'b0; cur.cycles = 0;
        end else if ({we_o, adr_o, dat_o, sel_o} != {cur.we, cur.adr, cur.dat, cur.sel}) begin
          cur.stable = 1'b0;
        end
        cur.cycles++;
        if (!no_ack && cur.cycles == ack_dly + 1) begin
          ack_i = 1'b1;
          dat_i = rdata;
          cur.acked = 1'b1;
          acked = 1'b1;
        end
      end
    end
  end

  // Transmit side: drives tx_ready, collects accepted bytes, flags tx_data changing while stalled
  initial begin
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b1;
    logic [7:0] prev_d = 8'h00;
    forever begin
      @(negedge clk_i);
      if (prev_v && !prev_r && !(tx_valid && tx_data == prev_d)) hold_err++;
      if (tx_valid && stall_cnt > 0) begin
        tx_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready) begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready) reply_q.push_back(tx_data);
      prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data;
    end
  end

  // Frame-level reference: what the host should see for a given command byte
  function automatic void ref_model(input logic [7:0] cmd, input logic [31:0] rd,
                                    output bit acc, output int n, output logic [31:0] rep);
    if (cmd == 8'h57) begin
      acc = 1'b1; n = 1; rep = 32'h4B;
    end else if (cmd == 8'h52) begin
      acc = 1'b1; n = 4; rep = rd;
    end else begin
      acc = 1'b0; n = 1; rep = 32'h45;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk_i);
    rx_valid = 1'b0; rx_data = $urandom;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat, input int gap_max);
    logic [7:0] b[9];
    int n;
    b[0] = cmd;
    for (int i = 0; i < 4; i++) begin
      b[1 + i] = adr[31 - 8 * i -: 8];
      b[5 + i] = dat[31 - 8 * i -: 8];
    end
    n = (cmd == 8'h57) ? 9 : ((cmd == 8'h52) ? 5 : 1);
    for (int i = 0; i < n; i++) begin
      send_byte(b[i]);
      repeat ($urandom_range(0, gap_max)) @(negedge clk_i);
    end
  endtask

  task automatic clear_logs();
    reply_q.delete();
    acc_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy_o && t < 400) begin
      @(negedge clk_i);
      t++;
    end
    check(!busy_o, {tag, ":idle"}, 64'(busy_o), 64'h0);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic check_frame(input string tag, input bit e_acc, input bit e_we, input logic [31:0] e_adr,
                             input logic [31:0] e_dat, input int e_n, input logic [31:0] e_rep);
    logic [31:0] got = 32'h0;
    wait_idle(tag);
    foreach (reply_q[i]) got = {got[23:0], reply_q[i]};
    check(reply_q.size() == e_n && got == e_rep, {tag, ":reply"},
          {32'(reply_q.size()), got}, {32'(e_n), e_rep});
    check(acc_q.size() == int'(e_acc), {tag, ":nacc"}, 64'(acc_q.size()), 64'(e_acc));
    if (e_acc && acc_q.size() == 1) begin
      check(acc_q[0].we == e_we && acc_q[0].adr == e_adr && acc_q[0].sel == 4'hF &&
            acc_q[0].stable && acc_q[0].acked && (!e_we || acc_q[0].dat == e_dat),
            {tag, ":access"}, {acc_q[0].adr, acc_q[0].dat}, {e_adr, e_dat});
    end
  endtask

  vec_t vecs[7];

  initial begin
    string tag;
    bit    m_acc;
    int    m_n;
    logic [31:0] m_rep;
    logic [7:0]  cmd;
    logic [31:0] adr, dat;
    int t;

    vecs[0] = '{8'h57, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 2, 1'b1, 1, 32'h0000_004B};
    vecs[1] = '{8'h52, 32'h3002_0008, 32'h0000_0000, 32'h1234_5678, 1, 1'b1, 4, 32'h1234_5678};
    vecs[2] = '{8'hAA, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1, 32'h0000_0045};
    vecs[3] = '{8'h52, 32'h3004_0010, 32'h0000_0000, 32'hCAFE_F00D, 0, 1'b1, 4, 32'hCAFE_F00D};
    vecs[4] = '{8'h57, 32'h3004_0000, 32'h0102_0304, 32'h0000_0000, 0, 1'b1, 1, 32'h0000_004B};
    vecs[5] = '{8'h00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1, 32'h0000_0045};
    vecs[6] = '{8'h57, 32'h3000_0003, 32'h0000_0000, 32'h0000_0000, 5, 1'b1, 1, 32'h0000_004B};

    repeat (3) @(negedge clk_i);
    check({cyc_o, stb_o, we_o, tx_valid, busy_o, sel_o, adr_o, dat_o, tx_data} == 80'h0,
          "reset_state", {cyc_o, stb_o, we_o, tx_valid, busy_o, sel_o, tx_data}, 64'h0);
    rst_i = 1'b0;
    clear_logs();

    foreach (vecs[i]) begin
      $sformat(tag, "vec%0d", i);
      ack_dly = vecs[i].dly;
      rdata   = vecs[i].rdata;
      clear_logs();
      run_frame(vecs[i].cmd, vecs[i].adr, vecs[i].dat, 1);
      check_frame(tag, vecs[i].e_acc, vecs[i].cmd == 8'h57, vecs[i].adr, vecs[i].dat,
                  vecs[i].e_n, vecs[i].e_rep);
    end

    // Backpressure on the read reply, with stray bytes sent while in RESP
    clear_logs();
    ack_dly = 1; rdata = 32'h1234_5678; stall_cnt = 10;
    run_frame(8'h52, 32'h3002_0008, 32'h0, 0);
    t = 0;
    while (!tx_valid && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    check(tx_valid && tx_data == 8'h12, "bp:first_byte", {tx_valid, tx_data}, {1'b1, 8'h12});
    send_byte(8'h57);
    send_byte(8'h52);
    send_byte(8'hAA);
    check_frame("bp", 1'b1, 1'b0, 32'h3002_0008, 32'h0, 4, 32'h1234_5678);
    check(hold_err == 0, "bp:hold", 64'(hold_err), 64'h0);

    // Unanswered bus cycle
    clear_logs();
    no_ack = 1'b1;
    run_frame(8'h52, 32'h3000_0000, 32'h0, 0);
`ifdef WB_TIMEOUT_EN
    wait_idle("tmo");
    check(reply_q.size() == 1 && reply_q[0] == 8'h54, "tmo:reply",
          64'(reply_q.size()), 64'h1);
    check(acc_q.size() == 1 && acc_q[0].cycles == 8 && !acc_q[0].acked, "tmo:stb_cycles",
          64'(acc_q.size() > 0 ? acc_q[0].cycles : 0), 64'd8);
    clear_logs();
    run_frame(8'h52, 32'h3000_0000, 32'h0, 0);
    repeat (3) @(negedge clk_i);
`else
    repeat (40) @(negedge clk_i);
`endif
    check(cyc_o && stb_o && !tx_valid && reply_q.size() == 0, "rst:pre",
          {cyc_o, stb_o, tx_valid}, 64'h6);
    rst_i = 1'b1;
    @(negedge clk_i);
    check(!cyc_o && !stb_o && !tx_valid && !busy_o, "rst:kill",
          {cyc_o, stb_o, tx_valid, busy_o}, 64'h0);
    rst_i = 1'b0;
    no_ack = 1'b0;
    repeat (5) @(negedge clk_i);
    check(reply_q.size() == 0, "rst:no_reply", 64'(reply_q.size()), 64'h0);
    clear_logs();
    ack_dly = 2;
    run_frame(8'h57, 32'h3000_0004, 32'hA5A5_5A5A, 0);
    check_frame("rst:after", 1'b1, 1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 1, 32'h4B);

    // Random frames against the reference model
    rand_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      t = $urandom_range(0, 9);
      cmd = (t < 4) ? 8'h57 : ((t < 8) ? 8'h52 : 8'($urandom));
      adr = $urandom; dat = $urandom;
      rdata = $urandom; ack_dly = $urandom_range(0, 4);
      ref_model(cmd, rdata, m_acc, m_n, m_rep);
      $sformat(tag, "rnd%0d", k);
      clear_logs();
      run_frame(cmd, adr, dat, 2);
      check_frame(tag, m_acc, cmd == 8'h57, adr, dat, m_n, m_rep);
    end
    check(hold_err == 0, "final:hold", 64'(hold_err), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
